// File: rtl/wave_sample_gen_pkg.sv
// Shared types and constants for the DDS sample source.
// Imported by the interface, the shaper LUT and the top.
package wave_sample_gen_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_SINE   = 2'b11
  } wave_e;

  localparam int DUTY_W         = 8;
  localparam int SINE_LUT_DEPTH = 64;

endpackage

// File: rtl/wave_sample_gen_if.sv
// Control and sample bundle between the sample source and its user.
// slave = sample source, master = controller / duty consumer.
interface wave_sample_gen_if #(
  parameter int PHASE_W = 16
);
  import wave_sample_gen_pkg::*;

  logic               en;
  logic [1:0]         wave_sel;
  logic [PHASE_W-1:0] freq;
  logic [DUTY_W-1:0]  sample;
  logic               sample_valid;

  modport master (
    output en, wave_sel, freq,
    input  sample, sample_valid
  );

  modport slave (
    input  en, wave_sel, freq,
    output sample, sample_valid
  );
endinterface

// File: rtl/wave_sample_gen_sine_quarter_lut.sv
// First quadrant of a sine, sampled at bin centres.
// 6-bit index in, 7-bit magnitude 0..127 out.
module sine_quarter_lut
  import wave_sample_gen_pkg::*;
(
  input  logic [5:0] idx,
  output logic [6:0] mag
);

  always_comb begin
    mag = 7'd0;
    unique case (idx)
      6'd0:  mag = 7'd2;
      6'd1:  mag = 7'd5;
      6'd2:  mag = 7'd8;
      6'd3:  mag = 7'd11;
      6'd4:  mag = 7'd14;
      6'd5:  mag = 7'd17;
      6'd6:  mag = 7'd20;
      6'd7:  mag = 7'd23;
      6'd8:  mag = 7'd26;
      6'd9:  mag = 7'd29;
      6'd10: mag = 7'd32;
      6'd11: mag = 7'd35;
      6'd12: mag = 7'd38;
      6'd13: mag = 7'd41;
      6'd14: mag = 7'd44;
      6'd15: mag = 7'd47;
      6'd16: mag = 7'd50;
      6'd17: mag = 7'd53;
      6'd18: mag = 7'd56;
      6'd19: mag = 7'd58;
      6'd20: mag = 7'd61;
      6'd21: mag = 7'd64;
      6'd22: mag = 7'd67;
      6'd23: mag = 7'd69;
      6'd24: mag = 7'd72;
      6'd25: mag = 7'd74;
      6'd26: mag = 7'd77;
      6'd27: mag = 7'd79;
      6'd28: mag = 7'd82;
      6'd29: mag = 7'd84;
      6'd30: mag = 7'd86;
      6'd31: mag = 7'd89;
      6'd32: mag = 7'd91;
      6'd33: mag = 7'd93;
      6'd34: mag = 7'd95;
      6'd35: mag = 7'd97;
      6'd36: mag = 7'd99;
      6'd37: mag = 7'd101;
      6'd38: mag = 7'd103;
      6'd39: mag = 7'd105;
      6'd40: mag = 7'd106;
      6'd41: mag = 7'd108;
      6'd42: mag = 7'd110;
      6'd43: mag = 7'd111;
      6'd44: mag = 7'd113;
      6'd45: mag = 7'd114;
      6'd46: mag = 7'd115;
      6'd47: mag = 7'd117;
      6'd48: mag = 7'd118;
      6'd49: mag = 7'd119;
      6'd50: mag = 7'd120;
      6'd51: mag = 7'd121;
      6'd52: mag = 7'd122;
      6'd53: mag = 7'd123;
      6'd54: mag = 7'd124;
      6'd55: mag = 7'd124;
      6'd56: mag = 7'd125;
      6'd57: mag = 7'd125;
      6'd58: mag = 7'd126;
      6'd59: mag = 7'd126;
      6'd60: mag = 7'd127;
      6'd61: mag = 7'd127;
      6'd62: mag = 7'd127;
      6'd63: mag = 7'd127;
      default: mag = 7'd0;
    endcase
  end

endmodule

// File: rtl/wave_sample_gen.sv
// DDS sample source: prescaled phase accumulator plus waveform shaper,
// emitting one registered 8-bit duty word per PWM frame.
module wave_sample_gen
  import wave_sample_gen_pkg::*;
#(
  parameter int PHASE_W       = 16,
  parameter int SAMPLE_PERIOD = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  wave_sample_gen_if.slave   bus
);

  localparam int PS_W = $clog2(SAMPLE_PERIOD);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(SAMPLE_PERIOD - 1);

  logic [PS_W-1:0]    ps_q, ps_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  wave_e              sel_q, sel_d;
  logic               tick;
  logic               tick_d_q;
  logic [DUTY_W-1:0]  sample_q, sample_d;
  logic               valid_q;

  logic [7:0]         p;
  logic [5:0]         idx;
  logic [6:0]         mag;
  logic [7:0]         shape;

  // Shape select is latched with the phase step so both change together.
  always_comb begin
    tick    = bus.en && (ps_q == PS_LAST);
    ps_d    = ps_q;
    phase_d = phase_q;
    sel_d   = sel_q;
    if (bus.en) begin
      ps_d = tick ? '0 : ps_q + 1'b1;
    end
    if (tick) begin
      phase_d = phase_q + bus.freq;
      sel_d   = wave_e'(bus.wave_sel);
    end
  end

  assign p   = phase_q[PHASE_W-1 -: 8];
  assign idx = p[6] ? ~p[5:0] : p[5:0];

  sine_quarter_lut u_lut (
    .idx (idx),
    .mag (mag)
  );

  always_comb begin
    shape = p;
    unique case (1'b1)
      sel_q == WAVE_SQUARE: shape = p[7] ? 8'h00 : 8'hFF;
      sel_q == WAVE_SAW:    shape = p;
      sel_q == WAVE_TRI:
        shape = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      sel_q == WAVE_SINE:
        shape = p[7] ? (8'd127 - {1'b0, mag})
                     : (8'd128 + {1'b0, mag});
      default: shape = p;
    endcase
  end

  // An in-flight tick_d completes even if en has dropped.
  always_comb begin
    sample_d = tick_d_q ? shape : sample_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q     <= '0;
      phase_q  <= '0;
      sel_q    <= WAVE_SQUARE;
      tick_d_q <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      ps_q     <= ps_d;
      phase_q  <= phase_d;
      sel_q    <= sel_d;
      tick_d_q <= tick;
      sample_q <= sample_d;
      valid_q  <= tick_d_q;
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_wave_sample_gen.sv
// Scoreboard bench for wave_sample_gen: a high-level model queues
// expected strobes; a monitor pops them as the DUT presents samples.
module tb_wave_sample_gen;

  localparam int PW = 16;
  localparam int SP = 256;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wave_sample_gen_if #(.PHASE_W(PW)) bus ();

  wave_sample_gen #(
    .PHASE_W       (PW),
    .SAMPLE_PERIOD (SP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int v;
    int due;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   cyc;
  int   held;
  int   en_cycles;
  int   m_phase;

  function automatic int lut(int i);
    real a;
    a = 3.14159265358979 * (i + 0.5) / 128.0;
    return $rtoi(127.0 * $sin(a) + 0.5);
  endfunction

  function automatic int shape(int sel, int ph);
    int p, q, r, idx, m;
    p = ph / (1 << (PW - 8));
    case (sel)
      0: return (p >= 128) ? 0 : 255;
      1: return p;
      2: return (p >= 128) ? 511 - 2 * p : 2 * p;
      default: begin
        q   = p / 64;
        r   = p % 64;
        idx = (q % 2 == 1) ? 63 - r : r;
        m   = lut(idx);
        return (q >= 2) ? 127 - m : 128 + m;
      end
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                 name, act, exp, cyc);
    end
  endtask

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_sample", int'(bus.sample), 0);
    check("reset_valid", int'(bus.sample_valid), 0);
    sb.delete();
    held      = 0;
    en_cycles = 0;
    m_phase   = 0;
    run(3);
    #2 rst_n = 1'b1;
  endtask

  // Model: every SP-th enabled cycle since reset is a tick; the phase
  // steps by freq and a strobe is due two cycles later.
  initial begin
    int c;
    cyc = 0;
    forever begin
      @(posedge clk);
      c   = cyc;
      cyc = cyc + 1;
      if (rst_n === 1'b1 && bus.en === 1'b1) begin
        en_cycles++;
        if (en_cycles % SP == 0) begin
          m_phase = (m_phase + int'(bus.freq)) % (1 << PW);
          sb.push_back('{v: shape(int'(bus.wave_sel), m_phase),
                         due: c + 2});
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) continue;
      if (bus.sample_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = sb.pop_front();
          check("strobe_value", int'(bus.sample), e.v);
          check("strobe_cycle", cyc, e.due);
          held = e.v;
        end
      end else begin
        check("hold_value", int'(bus.sample), held);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          check("missed_strobe_at", cyc, e.due);
        end
      end
    end
  end

  initial begin
    checks       = 0;
    failures     = 0;
    held         = 0;
    en_cycles    = 0;
    m_phase      = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b1;
    bus.wave_sel = 2'b01;
    bus.freq     = 16'h8000;
    run(4);
    #1;
    check("init_sample", int'(bus.sample), 0);
    check("init_valid", int'(bus.sample_valid), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    run(300);
    check("pre_reset_sample", int'(bus.sample), 8'h80);
    do_reset();

    bus.wave_sel = 2'b01;
    bus.freq     = 16'hF800;
    run(SP + 10);
    bus.freq = 16'h0100;
    run(9 * SP);

    do_reset();
    bus.wave_sel = 2'b00;
    bus.freq     = 16'h4000;
    run(8 * SP + 4);

    do_reset();
    bus.wave_sel = 2'b11;
    run(8 * SP + 4);

    do_reset();
    bus.wave_sel = 2'b10;
    bus.freq     = 16'h2000;
    run(8 * SP + 4);

    do_reset();
    bus.wave_sel = 2'b01;
    bus.freq     = 16'h1000;
    run(SP + 100);
    bus.en = 1'b0;
    run(50);
    bus.en = 1'b1;
    run(SP + 10);

    run(128);
    bus.wave_sel = 2'b00;
    run(2 * SP);

    for (int i = 0; i < 40; i++) begin
      bus.en       = ($urandom_range(0, 7) != 0);
      bus.wave_sel = 2'($urandom_range(0, 3));
      bus.freq     = 16'($urandom);
      if ($urandom_range(0, 19) == 0) do_reset();
      run($urandom_range(1, 200));
    end

    bus.en = 1'b1;
    run(2 * SP + 4);
    bus.en = 1'b0;
    run(4);
    check("drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
